// File: rtl/piezo_pkg.sv
// Shared constants for the piezo keyboard: note half-period table, FSM encoding, clock rate.
package piezo_pkg;

  localparam int unsigned CLK_HZ       = 1_000_000;
  localparam int unsigned NOTE_W       = 12;
  localparam int unsigned NOTE_ENTRIES = 16;

  typedef logic [NOTE_W-1:0] note_t;

  // Half-period counts at CLK_HZ; entries above 7 repeat the top note.
  localparam note_t NOTE_TABLE [NOTE_ENTRIES] = '{
    12'd1912, 12'd1703, 12'd1517, 12'd1431, 12'd1275, 12'd1136, 12'd1012, 12'd955,
    12'd955,  12'd955,  12'd955,  12'd955,  12'd955,  12'd955,  12'd955,  12'd955
  };

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPlay    = 2'd1,
    StSustain = 2'd2
  } state_e;

endpackage

// File: rtl/piezo_tone_div.sv
// Half-period counter and toggle flop; the half-period only reloads at a toggle edge or while stopped.
module piezo_tone_div
  import piezo_pkg::*;
#(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] half,
  input  logic             reload_ok,
  output logic             piezo,
  output logic             half_edge
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             piezo_q, piezo_d;

  assign half_edge = run && (cnt_q == half_q - CNT_W'(1));
  assign piezo     = piezo_q;

  always_comb begin
    cnt_d   = cnt_q;
    half_d  = half_q;
    piezo_d = piezo_q;
    if (!run) begin
      cnt_d   = '0;
      piezo_d = 1'b0;
      if (reload_ok) half_d = half;
    end else if (half_edge) begin
      cnt_d   = '0;
      piezo_d = ~piezo_q;
      if (reload_ok) half_d = half;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      half_q  <= '0;
      piezo_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      piezo_q <= piezo_d;
    end
  end

endmodule

// File: rtl/piezo_keyboard.sv
// Single-voice keyboard tone generator, lowest pressed key wins, octave up-shift.
// Define PIEZO_SUSTAIN_EN to keep the tone running for SUSTAIN_CYC cycles after release.
module piezo_keyboard
  import piezo_pkg::*;
#(
  parameter int unsigned N_KEYS      = 8,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned SUSTAIN_CYC = 50000,
  parameter int unsigned SUS_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  input  logic [1:0]        octave,
  output logic              piezo,
  output logic              busy,
  output logic [3:0]        note_idx
);

  state_e           state_q, state_d;
  logic [3:0]       note_idx_q, note_idx_d;
  logic [3:0]       sel;
  logic             any;
  logic [CNT_W-1:0] tbl_half, shifted, eff_half;
  logic             run, reload_ok, half_edge;

  always_comb begin
    sel = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (key[i]) sel = 4'(i);
    end
  end

  assign any      = |key;
  assign tbl_half = CNT_W'(NOTE_TABLE[sel]);
  assign shifted  = tbl_half >> octave;
  assign eff_half = (shifted == '0) ? CNT_W'(1) : shifted;

`ifdef PIEZO_SUSTAIN_EN
  logic [SUS_W-1:0] sus_cnt_q, sus_cnt_d;
`else
  logic unused_sus_cfg;
  assign unused_sus_cfg = ^{SUSTAIN_CYC, SUS_W};
`endif

  always_comb begin
    state_d    = state_q;
    note_idx_d = note_idx_q;
    reload_ok  = 1'b0;
`ifdef PIEZO_SUSTAIN_EN
    sus_cnt_d  = sus_cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (any) begin
          state_d    = StPlay;
          note_idx_d = sel;
          reload_ok  = 1'b1;
        end
      end
      StPlay: begin
        if (any) begin
          // Pitch follows the keys only at a toggle edge, so no runt pulses.
          reload_ok = 1'b1;
          if (half_edge) note_idx_d = sel;
        end else begin
`ifdef PIEZO_SUSTAIN_EN
          state_d   = StSustain;
          sus_cnt_d = SUS_W'(SUSTAIN_CYC - 1);
`else
          state_d    = StIdle;
          note_idx_d = '0;
`endif
        end
      end
`ifdef PIEZO_SUSTAIN_EN
      StSustain: begin
        if (any) begin
          state_d = StPlay;
        end else if (sus_cnt_q == '0) begin
          state_d    = StIdle;
          note_idx_d = '0;
        end else begin
          sus_cnt_d = sus_cnt_q - SUS_W'(1);
        end
      end
`endif
      default: begin
        state_d    = StIdle;
        note_idx_d = '0;
      end
    endcase
  end

  // Stopped on the way into IDLE too, so piezo and cnt clear on that same clock.
  assign run = (state_q != StIdle) && (state_d != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      note_idx_q <= '0;
`ifdef PIEZO_SUSTAIN_EN
      sus_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      note_idx_q <= note_idx_d;
`ifdef PIEZO_SUSTAIN_EN
      sus_cnt_q  <= sus_cnt_d;
`endif
    end
  end

  assign busy     = (state_q != StIdle);
  assign note_idx = note_idx_q;

  piezo_tone_div #(
    .CNT_W(CNT_W)
  ) u_tone_div (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .half     (eff_half),
    .reload_ok(reload_ok),
    .piezo    (piezo),
    .half_edge(half_edge)
  );

endmodule

// File: tb/tb_piezo_keyboard.sv
// Directed bench for piezo_keyboard: timing of tone edges, pitch/octave changes, release and reset.
`timescale 1ns/1ps
module tb_piezo_keyboard;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key;
  logic [1:0] octave;
  logic       piezo;
  logic       busy;
  logic [3:0] note_idx;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n;
  int unsigned cyc = 0;
  int unsigned t0;
  logic        p_or, b_or;
  logic [3:0]  i_or;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piezo_keyboard #(
    .N_KEYS     (8),
    .CNT_W      (12),
    .SUSTAIN_CYC(50000),
    .SUS_W      (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key     (key),
    .octave  (octave),
    .piezo   (piezo),
    .busy    (busy),
    .note_idx(note_idx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Negedges until piezo reaches level; -1 if the bound expires.
  task automatic wait_piezo(input logic level, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (piezo !== level && cycles < 60000);
    if (piezo !== level) cycles = -1;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (busy !== 1'b0 && cycles < 60000);
    if (busy !== 1'b0) cycles = -1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    key    = '0;
    octave = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    key    = '0;
    octave = '0;

    // Idle after reset
    do_reset();
    p_or = 1'b0;
    b_or = 1'b0;
    i_or = '0;
    repeat (1000) begin
      @(negedge clk);
      p_or |= piezo;
      b_or |= busy;
      i_or |= note_idx;
    end
    check_eq("idle_piezo", 32'(p_or), 0);
    check_eq("idle_busy", 32'(b_or), 0);
    check_eq("idle_note_idx", 32'(i_or), 0);

    // Key 0, octave 0
    key = 8'h01;
    @(negedge clk);
    check_eq("k0_busy", 32'(busy), 1);
    wait_piezo(1'b1, n);
    check_eq("k0_first_rise", n, 1912);
    wait_piezo(1'b0, n);
    check_eq("k0_high_time", n, 1912);

    // Keys 2 and 5: 2 wins, then switch to 5 mid-half
    do_reset();
    key = 8'h24;
    @(negedge clk);
    check_eq("k25_note_idx", 32'(note_idx), 2);
    wait_piezo(1'b1, n);
    check_eq("k25_first_rise", n, 1517);
    repeat (500) @(negedge clk);
    key = 8'h20;
    wait_piezo(1'b0, n);
    check_eq("k5_half_completes", n, 1017);
    check_eq("k5_note_idx", 32'(note_idx), 5);
    wait_piezo(1'b1, n);
    check_eq("k5_low_time", n, 1136);
    wait_piezo(1'b0, n);
    check_eq("k5_high_time", n, 1136);

    // Key 7 at octave 3, then drop to octave 0 mid-half
    do_reset();
    octave = 2'd3;
    key    = 8'h80;
    @(negedge clk);
    check_eq("k7_note_idx", 32'(note_idx), 7);
    wait_piezo(1'b1, n);
    check_eq("k7_oct3_rise", n, 119);
    wait_piezo(1'b0, n);
    check_eq("k7_oct3_high", n, 119);
    repeat (50) @(negedge clk);
    octave = 2'd0;
    wait_piezo(1'b1, n);
    check_eq("k7_oct_change_half", n, 69);
    wait_piezo(1'b0, n);
    check_eq("k7_oct0_high", n, 955);

    // Release behaviour
    do_reset();
`ifdef PIEZO_SUSTAIN_EN
    key = 8'h01;
    @(negedge clk);
    t0 = cyc;
    wait_piezo(1'b1, n);
    check_eq("sus_first_rise", n, 1912);
    wait_piezo(1'b0, n);
    check_eq("sus_high", n, 1912);
    repeat (300) @(negedge clk);
    key = 8'h00;
    wait_piezo(1'b1, n);
    check_eq("sus_rise_after_release", n, 1612);
    check_eq("sus_busy", 32'(busy), 1);
    repeat (20000 - 1612) @(negedge clk);
    key = 8'h01;
    wait_piezo(~piezo, n);
    check_eq("sus_repress_phase", (cyc - t0) % 1912, 0);
    check_eq("sus_repress_busy", 32'(busy), 1);
    key = 8'h00;
    wait_idle(n);
    check_eq("sus_expire", n, 50001);
    check_eq("sus_piezo_off", 32'(piezo), 0);
`else
    key = 8'h10;
    @(negedge clk);
    wait_piezo(1'b1, n);
    check_eq("rel_first_rise", n, 1275);
    check_eq("rel_note_idx", 32'(note_idx), 4);
    repeat (100) @(negedge clk);
    key = 8'h00;
    @(negedge clk);
    check_eq("rel_piezo", 32'(piezo), 0);
    check_eq("rel_busy", 32'(busy), 0);
    check_eq("rel_note_idx_clr", 32'(note_idx), 0);
`endif

    // Asynchronous reset mid-tone, key held through deassert
    do_reset();
    key = 8'h08;
    @(negedge clk);
    check_eq("rst_pre_note_idx", 32'(note_idx), 3);
    wait_piezo(1'b1, n);
    check_eq("rst_pre_rise", n, 1431);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_piezo", 32'(piezo), 0);
    check_eq("rst_async_busy", 32'(busy), 0);
    check_eq("rst_async_note_idx", 32'(note_idx), 0);
    key = 8'h01;
    repeat (3) @(negedge clk);
    check_eq("rst_held_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_restart_busy", 32'(busy), 1);
    wait_piezo(1'b1, n);
    check_eq("rst_restart_rise", n, 1912);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
